// File: rtl/gcd_stein_p.sv
// -----------------------------------------------------------------------------
// gcd_stein_p : parametrised binary (Stein) GCD engine with start/done handshake
//
// Build option:
//   GCD_CYCLES_EN  when defined, adds the `cycles` output reporting the number
//                  of reduction steps used by the last request.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   KW     width of the common power-of-two counter (derived, do not override)
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   start   in   request strobe, accepted only while idle
//   a, b    in   operands, sampled on the accepting edge
//   busy    out  high from the accepting edge until the done edge
//   done    out  one-cycle pulse, `out` valid from this cycle on
//   out     out  gcd(a,b), held until the next done
//   cycles  out  reduction steps of the last request (GCD_CYCLES_EN only)
// -----------------------------------------------------------------------------
module gcd_stein_p #(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
`ifdef GCD_CYCLES_EN
  ,
  output logic [WIDTH-1:0] cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_u, r_v, w_u_nxt, w_v_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_step;
  logic [WIDTH-1:0] w_diff_uv, w_diff_vu, w_restored;

  // Both differences are formed; only the non-negative one is ever used.
  assign w_diff_uv  = r_u - r_v;
  assign w_diff_vu  = r_v - r_u;
  // Restore the common power of two in one shot; result <= min(a,b) so no overflow.
  assign w_restored = r_u << r_k;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update selection
  always_comb begin
    w_state_nxt = r_state;
    w_u_nxt     = r_u;
    w_v_nxt     = r_v;
    w_k_nxt     = r_k;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_u_nxt     = a;
          w_v_nxt     = b;
          w_k_nxt     = {KW{1'b0}};
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_REDUCE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REDUCE: begin
        if ((r_u == {WIDTH{1'b0}}) || (r_v == {WIDTH{1'b0}})) begin
          // One operand zero: the other one is the answer (0 when both are).
          w_out_nxt   = r_u | r_v;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (r_u == r_v) begin
          // FINISH is folded into this edge, so it costs no extra cycle.
          w_out_nxt   = w_restored;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          case ({r_u[0], r_v[0]})
            2'b00: begin
              w_u_nxt = r_u >> 1;
              w_v_nxt = r_v >> 1;
              w_k_nxt = r_k + KW'(1);
            end
            2'b10: w_v_nxt = r_v >> 1;
            2'b01: w_u_nxt = r_u >> 1;
            2'b11: begin
              if (r_u >= r_v) begin
                w_u_nxt = w_diff_uv >> 1;
              end else begin
                w_v_nxt = w_diff_vu >> 1;
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_FINISH: begin
        // Never entered; kept only as a recovery path back to idle.
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_u    <= {WIDTH{1'b0}};
      r_v    <= {WIDTH{1'b0}};
      r_k    <= {KW{1'b0}};
      r_out  <= {WIDTH{1'b0}};
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_u    <= w_u_nxt;
      r_v    <= w_v_nxt;
      r_k    <= w_k_nxt;
      r_out  <= w_out_nxt;
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;

`ifdef GCD_CYCLES_EN
  logic [WIDTH-1:0] r_cycles, w_cycles_nxt;

  // Step counter: cleared on accept, counts reduction steps, holds when idle
  always_comb begin
    w_cycles_nxt = r_cycles;
    if ((r_state == ST_IDLE) && start) begin
      w_cycles_nxt = {WIDTH{1'b0}};
    end else if (w_step) begin
      w_cycles_nxt = r_cycles + WIDTH'(1);
    end else begin
      w_cycles_nxt = r_cycles;
    end
  end

  // Step counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles <= {WIDTH{1'b0}};
    end else begin
      r_cycles <= w_cycles_nxt;
    end
  end

  assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_gcd_stein_p.sv
// -----------------------------------------------------------------------------
// tb_gcd_stein_p : self-checking bench for gcd_stein_p (WIDTH=8 and WIDTH=16).
// A transaction-level model (Euclid for the result, a step count from the
// reduction rules for the latency) is compared with both DUTs every cycle;
// directed requests add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_gcd_stein_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        s8, s16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [7:0]  out8;
  logic [15:0] out16;
`ifdef GCD_CYCLES_EN
  logic [7:0]  cyc8;
  logic [15:0] cyc16;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  gcd_stein_p #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .out(out8)
`ifdef GCD_CYCLES_EN
    , .cycles(cyc8)
`endif
  );

  gcd_stein_p #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(s16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .out(out16)
`ifdef GCD_CYCLES_EN
    , .cycles(cyc16)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int gcd_ref(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of arithmetic reduction steps before a zero or equal pair appears.
  function automatic int steps_ref(input int x, input int y);
    int n = 0;
    for (int i = 0; i < 200; i++) begin
      if (x == 0 || y == 0 || x == y) break;
      if ((x % 2 == 0) && (y % 2 == 0)) begin x = x / 2; y = y / 2; end
      else if (y % 2 == 0) y = y / 2;
      else if (x % 2 == 0) x = x / 2;
      else if (x >= y) x = (x - y) / 2;
      else y = (y - x) / 2;
      n++;
    end
    return n;
  endfunction

  // Transaction model, index 0 = 8-bit DUT, 1 = 16-bit DUT
  bit m_busy[2], m_done[2];
  int m_rem[2], m_out[2], m_res[2], m_n[2], m_cyc[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit st;
      int av, bv, r;
      st = (i == 0) ? s8 : s16;
      av = (i == 0) ? int'(a8) : int'(a16);
      bv = (i == 0) ? int'(b8) : int'(b16);
      if (reset) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_out[i] <= 0; m_cyc[i] <= 0; m_rem[i] <= 0;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (st) begin
            m_busy[i] <= 1'b1;
            m_res[i]  <= gcd_ref(av, bv);
            m_n[i]    <= steps_ref(av, bv);
            m_rem[i]  <= steps_ref(av, bv) + 1;
            m_cyc[i]  <= 0;
          end
        end else begin
          r = m_rem[i] - 1;
          m_rem[i] <= r;
          if (r == 0) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_out[i]  <= m_res[i];
            m_cyc[i]  <= m_n[i];
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy8", busy8, m_busy[0]);
      chk("done8", done8, m_done[0]);
      chk("out8", out8, m_out[0]);
      chk("busy16", busy16, m_busy[1]);
      chk("done16", done16, m_done[1]);
      chk("out16", out16, m_out[1]);
`ifdef GCD_CYCLES_EN
      if (!m_busy[0]) chk("cycles8", cyc8, m_cyc[0]);
      if (!m_busy[1]) chk("cycles16", cyc16, m_cyc[1]);
`endif
    end
  end

  // Directed 8-bit request; exp_cyc < 0 means no cycles expectation
  task automatic req8(input int av, input int bv, input int exp_out, input int exp_lat, input int exp_cyc);
    int lat = 0;
    @(negedge clk); s8 = 1'b1; a8 = 8'(av); b8 = 8'(bv);
    @(posedge clk); #1;
    chk("busy8_after_accept", busy8, 1);
    @(negedge clk); s8 = 1'b0;
    while (lat < 40) begin
      @(posedge clk); lat++; #1;
      if (done8) break;
    end
    chk("latency8", lat, exp_lat);
    chk("result8", out8, exp_out);
    chk("busy8_at_done", busy8, 0);
`ifdef GCD_CYCLES_EN
    if (exp_cyc >= 0) chk("steps8", cyc8, exp_cyc);
`endif
  endtask

  initial begin
    int lat, dcount;
    reset = 1'b1; s8 = 1'b0; s16 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; a16 = 16'd0; b16 = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_out8", out8, 0);
    chk("rst_busy16", busy16, 0);
`ifdef GCD_CYCLES_EN
    chk("rst_cycles8", cyc8, 0);
`endif
    reset = 1'b0;

    // Pin the model with hand-computed values
    chk("model_gcd_48_18", gcd_ref(48, 18), 6);
    chk("model_steps_48_18", steps_ref(48, 18), 5);
    chk("model_steps_255_1", steps_ref(255, 1), 7);
    chk("model_gcd_0_37", gcd_ref(0, 37), 37);
    chk("model_gcd_40000_30000", gcd_ref(40000, 30000), 10000);
    chk("model_steps_21_14", steps_ref(21, 14), 2);

    req8(48, 18, 6, 6, 5);
    req8(0, 37, 37, 1, 0);
    req8(0, 0, 0, 1, 0);
    req8(255, 1, 1, 8, 7);
    req8(128, 128, 128, 1, 0);
    req8(37, 0, 37, 1, 0);
    req8(200, 75, 25, steps_ref(200, 75) + 1, -1);

    // 16-bit request
    @(negedge clk); s16 = 1'b1; a16 = 16'd40000; b16 = 16'd30000;
    @(posedge clk);
    @(negedge clk); s16 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); lat++; #1;
      if (done16) break;
    end
    chk("result16", out16, 10000);
    chk("latency16_bound", (lat <= 33) ? 1 : 0, 1);
    chk("latency16", lat, steps_ref(40000, 30000) + 1);

    // start while busy is ignored
    @(negedge clk); s8 = 1'b1; a8 = 8'd48; b8 = 8'd18;
    @(posedge clk);
    @(negedge clk); a8 = 8'd9; b8 = 8'd6;
    repeat (2) @(negedge clk);
    s8 = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) dcount++;
    end
    chk("ignore_single_done", dcount, 1);
    chk("ignore_result", out8, 6);

    // reset three cycles into a request
    @(negedge clk); s8 = 1'b1; a8 = 8'd48; b8 = 8'd18;
    @(posedge clk);
    @(negedge clk); s8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_out", out8, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    req8(21, 14, 7, 3, 2);

    // reset and start on the same edge: request dropped
    @(negedge clk); s8 = 1'b1; a8 = 8'd9; b8 = 8'd6; reset = 1'b1;
    @(negedge clk); s8 = 1'b0; reset = 1'b0;
    chk("rst_start_busy", busy8, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_stein_p.md
# gcd_stein_p

Parametrised binary (Stein) GCD engine with a start/done handshake: the next generation of the team's 8-bit GCD block. Operand width is generic and zero operands are handled explicitly. Final power-of-two restoration is a single-cycle barrel shift rather than an iterative loop. The block sits behind a bus or host FSM that issues one request at a time and waits for `done`.

## Interface
- `WIDTH`, default 8: operand/result width in bits, ≥ 2.
- `KW`, default `$clog2(WIDTH)+1`: width of the common-power-of-two counter (derived; do not override).

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `start`  in  1  request strobe; accepted only in IDLE.
- `a`  in  WIDTH  operand A; sampled on the accepting edge.
- `b`  in  WIDTH  operand B; sampled on the accepting edge.
- `busy`  out  1  high from the accepting edge until the `done` edge.
- `done`  out  1  one-cycle pulse; `out` is valid from this cycle on.
- `out`  out  WIDTH  gcd(a,b); held until the next `done`.
- `cycles`  out  WIDTH  number of reduction steps N used by the last request (present only with `GCD_CYCLES_EN`).

## Operation
- States: IDLE, REDUCE, FINISH.
- IDLE:
  - `start`=1 → u←a, v←b, k←0, state←REDUCE, `busy`←1.
  - `start`=0 → stay in IDLE.
- REDUCE performs one action per cycle, in priority order:
  - u==0 or v==0: `out`←u|v; go to IDLE, pulse `done`.
  - u==v: go to FINISH.
  - both even: u←u>>1, v←v>>1, k←k+1.
  - u odd, v even: v←v>>1.
  - u even, v odd: u←u>>1.
  - both odd, u≥v: u←(u−v)>>1.
  - both odd, u<v: v←(v−u)>>1.
- Every arithmetic action above counts as one reduction step (N increments).
- FINISH action is folded into the equality edge: `out`←u<<k, `done`←1, `busy`←0, state←IDLE.
  - The shift is combinational over WIDTH bits and truncated to WIDTH; it cannot overflow because the result is ≤ min(a,b).
- `k` never exceeds WIDTH−1. Subtraction is unsigned and is only taken when the minuend ≥ subtrahend.
- Zero cases: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0.
- `start` while `busy` is ignored; operands are not re-sampled.

## Timing
- Reset values: `out`=0, `done`=0, `busy`=0, `cycles`=0, state=IDLE. Internal u, v, k are don't-care.
- Reset mid-operation aborts the request: outputs take reset values, no `done` is produced.
- Reset and `start` on the same edge: reset wins and the request is dropped.
- `done` is registered at edge E0+N+1, where E0 is the accepting edge and N is the number of reduction steps.
  - Zero operands or equal operands: N=0, so `done` at E0+1.
- Worst case N ≤ 2·WIDTH, so latency ≤ 2·WIDTH+1 edges.
- A new `start` is accepted on the edge after the `done` edge at the earliest; back-to-back throughput is one request per N+2 cycles.
- `busy` falls on the same edge `done` rises.

## Configuration
- `GCD_CYCLES_EN` defined:
  - `cycles` port exists.
  - Cleared on accept; increments per reduction step.
  - Latched visible value equals N at `done` and holds until the next accept.
- `GCD_CYCLES_EN` undefined: `cycles` port and its counter are absent. All other behaviour and timing are identical.

## Test plan
- WIDTH=8, a=48, b=18, pulse `start` → `done` at E0+6, `out`=6, `cycles`=5.
- WIDTH=8, a=0, b=37 → `done` at E0+1, `out`=37. Then a=0, b=0 → `out`=0.
- WIDTH=8, a=255, b=1 → `out`=1, `cycles`=7. Then a=128, b=128 → `done` at E0+1, `out`=128.
- WIDTH=16, a=40000, b=30000 → `out`=10000; latency ≤ 33 edges.
- Assert `start` with a=9, b=6 while `busy` from an earlier a=48, b=18 request → ignored, `out`=6, single `done`.
- Assert `reset` 3 cycles into a request → `busy`=0, `done` never pulses, `out`=0. A following request a=21, b=14 returns 7.
